// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parity_pkg
// Description : Shared FSM state encoding and constants for parity_frame_check
// Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

  // Frame FSM: no beat yet / mid-frame / result waiting for the consumer
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Width of the optional error counter
  localparam int ERR_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/word_parity.sv
`default_nettype none
// ============================================================================
// Module      : word_parity
// Description : Combinational reduction-XOR (even parity) of one data word
// Revision    : 1.0 - initial release
// ============================================================================
module word_parity #(
  parameter int N = 8
) (
  input  logic [N-1:0] word,
  output logic         par
);

  assign par = ^word;

endmodule
`default_nettype wire

// File: rtl/parity_frame_check.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_check
// Description : Accumulates parity over FRAME_LEN data beats, compares the
//               generated frame parity with the received parity bit and
//               holds the result until the consumer accepts it.
//               Optional macro PARITY_ERR_CNT_EN adds a saturating 16-bit
//               count of accepted results that carried a parity error.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_check
  import parity_pkg::*;
#(
  parameter int N         = 8,
  parameter int FRAME_LEN = 4,
  parameter int ODD       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         din,
  input  logic                 din_par,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 dout,
`ifdef PARITY_ERR_CNT_EN
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
`else
  output logic                 err
`endif
);

  localparam int       CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic     ODD_BIT  = (ODD != 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             beat_par;
  logic             acc_next;
  logic             gen_par;
  logic             accept;
  logic             last_beat;

  word_parity #(.N(N)) u_word_parity (
    .word (din),
    .par  (beat_par)
  );

  // Running parity including the current beat, and final sense-adjusted bit
  assign acc_next  = acc ^ beat_par;
  assign gen_par   = acc_next ^ ODD_BIT;
  assign in_ready  = (state != HOLD);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == LAST_CNT);

  // Frame FSM with registered result outputs; rst beats flush beats handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= 1'b0;
      out_valid <= 1'b0;
      dout      <= 1'b0;
      err       <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= 1'b0;
      out_valid <= 1'b0;
      dout      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (last_beat) begin
              state     <= HOLD;
              cnt       <= '0;
              acc       <= 1'b0;
              out_valid <= 1'b1;
              dout      <= gen_par;
              err       <= gen_par ^ din_par;
            end else begin
              state <= ACCUM;
              cnt   <= cnt + 1'b1;
              acc   <= acc_next;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          acc       <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARITY_ERR_CNT_EN
  // Saturating count of delivered results flagged as errors; survives flush
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (!flush && out_valid && out_ready && err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_frame_check
// Description : Directed self-checking bench for parity_frame_check
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_check;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // Main instance: N=8, FRAME_LEN=4, ODD=0
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] din = 8'h00;
  logic       din_par = 1'b0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       dout;
  logic       err;

  // Second instance: N=8, FRAME_LEN=1, ODD=1
  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [7:0] din1 = 8'h00;
  logic       din_par1 = 1'b0;
  logic       out_valid1;
  logic       out_ready1 = 1'b0;
  logic       dout1;
  logic       err1;

`ifdef PARITY_ERR_CNT_EN
  logic [15:0] err_cnt;
  logic [15:0] err_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  parity_frame_check #(.N(8), .FRAME_LEN(4), .ODD(0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .din_par   (din_par),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
`ifdef PARITY_ERR_CNT_EN
    .err       (err),
    .err_cnt   (err_cnt)
`else
    .err       (err)
`endif
  );

  parity_frame_check #(.N(8), .FRAME_LEN(1), .ODD(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .din       (din1),
    .din_par   (din_par1),
    .flush     (1'b0),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .dout      (dout1),
`ifdef PARITY_ERR_CNT_EN
    .err       (err1),
    .err_cnt   (err_cnt1)
`else
    .err       (err1)
`endif
  );

  // Present one beat for exactly one clock edge
  task automatic send_beat(input logic [7:0] d, input logic p);
    in_valid = 1'b1;
    din      = d;
    din_par  = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // One-cycle result handshake on the main instance
  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dout !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b dout=%b err=%b required 1 0 0 0",
               in_ready, out_valid, dout, err);
    end
`ifdef PARITY_ERR_CNT_EN
    total++;
    if (err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_err_cnt: got %0d required 0", err_cnt);
    end
`endif
  endtask

  task automatic test_good_frame();
    send_beat(8'h01, 1'b0);
    send_beat(8'h03, 1'b0);
    send_beat(8'h00, 1'b0);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL good_before_last: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    send_beat(8'h00, 1'b1);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || dout !== 1'b1 || err !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL good_result: out_valid=%b dout=%b err=%b in_ready=%b required 1 1 0 0",
               out_valid, dout, err, in_ready);
    end
    handshake();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL good_after_hs: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_err_frame();
    send_beat(8'h01, 1'b0);
    send_beat(8'h03, 1'b0);
    send_beat(8'h00, 1'b0);
    send_beat(8'h00, 1'b0);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || dout !== 1'b1 || err !== 1'b1) begin
      bad++;
      $display("FAIL err_result: out_valid=%b dout=%b err=%b required 1 1 1", out_valid, dout, err);
    end
`ifdef PARITY_ERR_CNT_EN
    total++;
    if (err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL err_cnt_pre: got %0d required 0", err_cnt);
    end
`endif
    handshake();
    @(negedge clk);
`ifdef PARITY_ERR_CNT_EN
    total++;
    if (err_cnt !== 16'd1) begin
      bad++;
      $display("FAIL err_cnt_post: got %0d required 1", err_cnt);
    end
`endif
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL err_after_hs: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    send_beat(8'h07, 1'b0);
    send_beat(8'h00, 1'b0);
    send_beat(8'h00, 1'b0);
    send_beat(8'h00, 1'b1);
    // Offer beats while the result is pending; none may be taken
    in_valid = 1'b1;
    din      = 8'h01;
    din_par  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || dout !== 1'b1 || err !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable[%0d]: in_ready=%b out_valid=%b dout=%b err=%b required 0 1 1 0",
                 i, in_ready, out_valid, dout, err);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    // Next frame: four beats of 8'h01 -> parity 0; needs all four beats
    send_beat(8'h01, 1'b0);
    send_beat(8'h01, 1'b0);
    send_beat(8'h01, 1'b0);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL next_frame_early: out_valid=%b required 0", out_valid);
    end
    send_beat(8'h01, 1'b0);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || dout !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL next_frame: out_valid=%b dout=%b err=%b required 1 0 0", out_valid, dout, err);
    end
    handshake();
  endtask

  task automatic test_flush();
    send_beat(8'h01, 1'b0);
    send_beat(8'h00, 1'b0);
    // Flush together with a valid beat: the beat must be dropped
    flush    = 1'b1;
    in_valid = 1'b1;
    din      = 8'h01;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_state: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFF, 1'b0);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_count: out_valid=%b required 0", out_valid);
    end
    send_beat(8'hFF, 1'b0);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || dout !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL flush_frame: out_valid=%b dout=%b err=%b required 1 0 0", out_valid, dout, err);
    end
    // Flush wins over a simultaneous handshake
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_hold: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midframe();
    send_beat(8'h01, 1'b0);
    send_beat(8'h01, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
`ifdef PARITY_ERR_CNT_EN
    total++;
    if (err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL rst_mid_err_cnt: got %0d required 0", err_cnt);
    end
`endif
    // A fresh frame of 8'h01,0,0,0 needs all four beats after the reset
    send_beat(8'h01, 1'b0);
    send_beat(8'h00, 1'b0);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_count: out_valid=%b required 0", out_valid);
    end
    send_beat(8'h00, 1'b0);
    send_beat(8'h00, 1'b1);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || dout !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_frame: out_valid=%b dout=%b err=%b required 1 1 0", out_valid, dout, err);
    end
    handshake();
  endtask

  task automatic test_odd_single();
    @(negedge clk);
    total++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      bad++;
      $display("FAIL odd_idle: out_valid=%b in_ready=%b required 0 1", out_valid1, in_ready1);
    end
    in_valid1 = 1'b1;
    din1      = 8'h00;
    din_par1  = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid1 !== 1'b1 || dout1 !== 1'b1 || err1 !== 1'b0) begin
      bad++;
      $display("FAIL odd_single: out_valid=%b dout=%b err=%b required 1 1 0", out_valid1, dout1, err1);
    end
    out_ready1 = 1'b1;
    @(posedge clk);
    #1;
    out_ready1 = 1'b0;
    // Word with one set bit under odd sense gives 0; received 1 flags an error
    in_valid1 = 1'b1;
    din1      = 8'h01;
    din_par1  = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid1 !== 1'b1 || dout1 !== 1'b0 || err1 !== 1'b1) begin
      bad++;
      $display("FAIL odd_single_err: out_valid=%b dout=%b err=%b required 1 0 1", out_valid1, dout1, err1);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_err_frame();
    test_backpressure();
    test_flush();
    test_reset_midframe();
    test_odd_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
